div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 Port clk, input, 1: clock; all state updates on its rising edge.
REQ-002 Port rst, input, 1: reset, synchronous, active-low (rst==0 resets on the next clk edge).
REQ-003 Port signed_div_i, input, 1: 1 = signed (DIV), 0 = unsigned (DIVU).
REQ-004 Port opdata1_i, input, 32: dividend.
REQ-005 Port opdata2_i, input, 32: divisor.
REQ-006 Port start_i, input, 1: request from ex stage; held high until the result is consumed.
REQ-007 Port annul_i, input, 1: cancel an in-flight division (pipeline flush).
REQ-008 Port result_o, output, 64: {remainder[63:32], quotient[31:0]}, destined for HI/LO.
REQ-009 Port ready_o, output, 1: result_o valid.

Function
REQ-010 The divider SHALL use a four-state FSM: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END.
REQ-011 In DIV_FREE with start_i=1 and annul_i=0, the divider SHALL latch operands and signed_div_i, then go to DIV_BY_ZERO if opdata2_i==0, else to DIV_ON with cnt=0.
REQ-012 On latch with signed_div_i=1, the divider SHALL replace negative operands by their two's-complement magnitude and record the sign of both operands.
REQ-013 The divider SHALL ignore operand or signed_div_i changes after the latch until the FSM returns to DIV_FREE.
REQ-014 DIV_ON SHALL perform one restoring step per cycle on a 65-bit working register initialised {32'b0, |dividend|, 1'b0}.
REQ-015 Restoring step: diff = {1'b0, work[63:32]} - {1'b0, |divisor|}; if diff[32]=1, shift work left by 1, else work = {diff[31:0], work[31:0], 1'b1}; cnt increments.
REQ-016 When cnt==32, the divider SHALL apply sign fix-up, write result_o, set ready_o=1, and enter DIV_END.
REQ-017 Sign fix-up (signed only): negate quotient if operand signs differ; negate remainder if dividend was negative.
REQ-018 Latency SHALL be fixed: ready_o rises 34 clk edges after the edge sampling start_i (1 latch + 32 steps + 1 fix-up).
REQ-019 DIV_BY_ZERO SHALL go to DIV_END on the next edge with result_o=0 and ready_o=1 (latency 2 edges); no exception is raised.
REQ-020 DIV_END SHALL hold result_o and ready_o while start_i=1; when start_i=0, the FSM SHALL go to DIV_FREE with ready_o=0 and result_o=0.
REQ-021 annul_i=1 in DIV_ON or DIV_BY_ZERO SHALL force DIV_FREE on the next edge with ready_o=0, result_o=0, and no partial result visible.
REQ-022 annul_i=1 in DIV_FREE SHALL block acceptance; annul_i in DIV_END SHALL have no effect.
REQ-023 start_i pulses in DIV_ON, DIV_BY_ZERO, or DIV_END SHALL NOT restart the division.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0, with no trap.

Reset
REQ-025 On rst==0 at a clk edge: state=DIV_FREE, cnt=0, working register=0, result_o=0, ready_o=0.
REQ-026 Reset asserted mid-division SHALL abandon it; the first start_i after release SHALL start a fresh division.

Structure
REQ-027 FSM state encodings (2-bit), DivResultReady/DivResultNotReady, DivStart/DivStop, and the signed/unsigned select constants SHALL reside in the shared defs.v.
REQ-028 The block SHALL be a single module with no sub-module; ex instantiates no copy of it, and the id/ex top level wires it beside ex, with ex asserting a stall request while start_i=1 and ready_o=0.

Verification
REQ-029 Unsigned 0xFFFFFFFF / 0x00000010: result_o = {0x0000000F, 0x0FFFFFFF}, with ready_o high exactly 34 edges after start.
REQ-030 Signed -7 / 2 (0xFFFFFFF9 / 0x00000002): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; and 7 / -2: quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-031 Divisor 0 (any dividend, either mode): ready_o high 2 edges after start, result_o=0.
REQ-032 annul_i pulsed at step 10: FSM returns to DIV_FREE, ready_o stays 0; a restart with 100/7 gives {2, 14} after 34 edges.
REQ-033 start_i held 5 cycles in DIV_END: result_o stable; start_i low sets ready_o=0 on the next edge; operand changes during DIV_ON do not alter the result.
REQ-034 rst=0 asserted at step 20, then released: all outputs 0, and the next division (signed 0x80000000 / 0xFFFFFFFF) returns {0, 0x80000000}.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared FSM encodings, handshake constants and operand helper for the divider
package div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_SIGNED           = 1'b1;
    localparam logic DIV_UNSIGNED         = 1'b0;
    localparam logic [5:0] DIV_STEPS      = 6'd32;

    // Magnitude of an operand; negative values only count as negative in signed mode.
    function automatic logic [31:0] div_mag(input logic s, input logic [31:0] v);
        return (s && v[31]) ? ~v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/div.sv
// div: 32-bit multi-cycle restoring divider (signed/unsigned) producing {remainder, quotient}
module div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_t  r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_work;
    logic [31:0] r_divisor;
    logic        r_neg_q;
    logic        r_neg_r;

    logic [32:0] w_diff;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;
    logic        w_signed;

    // Trial subtraction of one restoring step and the signed fix-up of the final result.
    always_comb begin
        w_diff     = {1'b0, r_work[63:32]} - {1'b0, r_divisor};
        w_quot     = r_work[31:0];
        w_rem      = r_work[64:33];
        w_quot_fix = r_neg_q ? ~w_quot + 32'd1 : w_quot;
        w_rem_fix  = r_neg_r ? ~w_rem + 32'd1 : w_rem;
        w_signed   = signed_div_i == DIV_SIGNED;
    end

    // Division FSM: latch operands, iterate 32 restoring steps, hold the result until released.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= DIV_FREE;
            r_cnt     <= 6'd0;
            r_work    <= 65'd0;
            r_divisor <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            result_o  <= 64'd0;
            ready_o   <= DIV_RESULT_NOT_READY;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    if (start_i == DIV_START && !annul_i) begin
                        r_divisor <= div_mag(w_signed, opdata2_i);
                        r_work    <= {32'd0, div_mag(w_signed, opdata1_i), 1'b0};
                        r_cnt     <= 6'd0;
                        r_neg_q   <= w_signed && (opdata1_i[31] ^ opdata2_i[31]);
                        r_neg_r   <= w_signed && opdata1_i[31];
                        r_state   <= (opdata2_i == 32'd0) ? DIV_BY_ZERO : DIV_ON;
                    end
                end
                DIV_BY_ZERO: begin
                    r_state  <= annul_i ? DIV_FREE : DIV_END;
                    result_o <= 64'd0;
                    ready_o  <= annul_i ? DIV_RESULT_NOT_READY : DIV_RESULT_READY;
                end
                DIV_ON: begin
                    if (annul_i) begin
                        r_state  <= DIV_FREE;
                        r_cnt    <= 6'd0;
                        r_work   <= 65'd0;
                        result_o <= 64'd0;
                        ready_o  <= DIV_RESULT_NOT_READY;
                    end else if (r_cnt != DIV_STEPS) begin
                        r_work <= w_diff[32] ? {r_work[63:0], 1'b0} : {w_diff[31:0], r_work[31:0], 1'b1};
                        r_cnt  <= r_cnt + 6'd1;
                    end else begin
                        r_state  <= DIV_END;
                        r_cnt    <= 6'd0;
                        result_o <= {w_rem_fix, w_quot_fix};
                        ready_o  <= DIV_RESULT_READY;
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        r_state  <= DIV_FREE;
                        result_o <= 64'd0;
                        ready_o  <= DIV_RESULT_NOT_READY;
                    end
                end
                default: r_state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// tb_div: randomized and directed checks of div against an arithmetic reference model
module tb_div;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = 32'd0;
    logic [31:0] opdata2_i = 32'd0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int n_chk = 0;
    int n_fail = 0;

    logic        m_busy = 1'b0;
    logic        m_ready = 1'b0;
    logic [63:0] m_result = 64'd0;
    logic [63:0] m_pend = 64'd0;
    int          m_left = 0;

    div dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o)
    );

    always #5 clk = ~clk;

    // Reference {remainder, quotient} from plain 64-bit arithmetic (truncating division).
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return 64'd0;
        x = s ? longint'($signed(a)) : longint'({32'd0, a});
        y = s ? longint'($signed(b)) : longint'({32'd0, b});
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Transaction-level model: a result appears a fixed number of edges after acceptance.
    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 1'b0; m_ready = 1'b0; m_result = 64'd0;
        end else if (m_ready) begin
            if (!start_i) begin m_ready = 1'b0; m_result = 64'd0; end
        end else if (m_busy) begin
            if (annul_i) m_busy = 1'b0;
            else begin
                m_left = m_left - 1;
                if (m_left == 0) begin m_busy = 1'b0; m_ready = 1'b1; m_result = m_pend; end
            end
        end else if (start_i && !annul_i) begin
            m_busy = 1'b1;
            m_left = (opdata2_i == 32'd0) ? 1 : 33;
            m_pend = ref_div(signed_div_i, opdata1_i, opdata2_i);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b, input int hold,
                       input logic lit, input logic [63:0] exp, input logic mess, input logic annul_end);
        int n;
        logic got;
        signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (mess && n == 5) begin
                signed_div_i = ~s; opdata1_i = $urandom; opdata2_i = $urandom_range(0, 1) ? 32'd0 : $urandom;
            end
            if (mess && n == 7) start_i = 1'b0;
            if (mess && n == 8) start_i = 1'b1;
            got = ready_o;
        end
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL timeout: ready_o never rose within %0d edges", n);
        end else begin
            check("latency", 64'(n), (b == 32'd0) ? 64'd2 : 64'd34);
            if (lit) check("result", result_o, exp);
        end
        annul_i = annul_end;
        repeat (hold) @(negedge clk);
        annul_i = 1'b0;
        if (got && lit) check("held_result", result_o, exp);
        start_i = 1'b0;
        @(negedge clk);
        check("ready_drop", 64'(ready_o), 64'd0);
    endtask

    initial begin
        // Per-cycle comparison of DUT outputs against the model.
        fork
            forever begin
                @(negedge clk);
                n_chk++;
                if (ready_o !== m_ready || result_o !== m_result) begin
                    n_fail++;
                    $display("FAIL cycle_cmp @%0t: ready=%b result=%h, expected ready=%b result=%h",
                             $time, ready_o, result_o, m_ready, m_result);
                end
            end
        join_none

        check("model_u_ffff_10", ref_div(1'b0, 32'hFFFFFFFF, 32'h10), {32'h0000000F, 32'h0FFFFFFF});
        check("model_s_m7_2", ref_div(1'b1, 32'hFFFFFFF9, 32'h2), {32'hFFFFFFFF, 32'hFFFFFFFD});
        check("model_s_7_m2", ref_div(1'b1, 32'h7, 32'hFFFFFFFE), {32'h00000001, 32'hFFFFFFFD});
        check("model_s_min_m1", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF), {32'h0, 32'h80000000});
        check("model_100_7", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});

        repeat (2) @(negedge clk);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        run(1'b0, 32'hFFFFFFFF, 32'h10, 1, 1'b1, {32'h0000000F, 32'h0FFFFFFF}, 1'b0, 1'b0);
        run(1'b1, 32'hFFFFFFF9, 32'h2, 1, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 1'b0);
        run(1'b1, 32'h7, 32'hFFFFFFFE, 5, 1'b1, {32'h00000001, 32'hFFFFFFFD}, 1'b1, 1'b1);
        run(1'b0, 32'h12345678, 32'h0, 2, 1'b1, 64'd0, 1'b0, 1'b0);
        run(1'b1, 32'h80000001, 32'h0, 0, 1'b1, 64'd0, 1'b0, 1'b1);

        // Annul while idle must block acceptance.
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
        repeat (3) @(negedge clk);
        check("annul_idle_ready", 64'(ready_o), 64'd0);
        start_i = 1'b0; annul_i = 1'b0;
        @(negedge clk);

        // Annul mid-division, then a fresh division.
        signed_div_i = 1'b0; opdata1_i = $urandom; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        repeat (40) @(negedge clk);
        check("annul_ready", 64'(ready_o), 64'd0);
        check("annul_result", result_o, 64'd0);
        run(1'b0, 32'd100, 32'd7, 1, 1'b1, {32'd2, 32'd14}, 1'b0, 1'b0);

        // Reset mid-division, then the most-negative corner case.
        signed_div_i = 1'b1; opdata1_i = $urandom; opdata2_i = 32'd5; start_i = 1'b1;
        repeat (21) @(negedge clk);
        rst = 1'b0; start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        run(1'b1, 32'h80000000, 32'hFFFFFFFF, 1, 1'b1, {32'h0, 32'h80000000}, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic        s;
            logic [31:0] a, b;
            s = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
                default: b = $urandom;
            endcase
            run(s, a, b, $urandom_range(0, 3), 1'b1, ref_div(s, a, b), 1'($urandom_range(0, 1)) && b != 32'd0,
                1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
